// File: rtl/binary_counter_161.sv
// ---------------------------------------------------------------------------
// binary_counter_161
//   Presettable synchronous binary counter, 74x161 equivalent. Serves as the
//   microcode step counter: pen gives a synchronous step reset/jump, cep/cet
//   allow stalling, and tc lets several instances cascade into a wider count.
//
// Optional feature (macro COUNTER161_OE_EN):
//   Adds active-low output enable oen. q floats (all Z) while oen=1; the
//   internal count and tc keep running regardless of oen.
//
// Parameters:
//   WIDTH  counter width in bits (default 4)
//
// Ports:
//   clk   in   1      counting clock, rising edge
//   mrn   in   1      master reset, asynchronous, active-low
//   pen   in   1      parallel load enable, synchronous, active-low
//   cep   in   1      count enable (parallel), active-high
//   cet   in   1      count enable (trickle), active-high; also gates tc
//   d     in   WIDTH  parallel load data
//   oen   in   1      output enable, active-low (COUNTER161_OE_EN only)
//   q     out  WIDTH  counter state
//   tc    out  1      terminal count = cet & (q == all-ones)
// ---------------------------------------------------------------------------
module binary_counter_161 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             mrn,
    input  logic             pen,
    input  logic             cep,
    input  logic             cet,
    input  logic [WIDTH-1:0] d,
`ifdef COUNTER161_OE_EN
    input  logic             oen,
`endif
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    logic [WIDTH-1:0] cnt_q;
    logic             cnt_en;
    logic             all_ones;

    // Both enables must be high to advance; cet is the ripple input when
    // cascading, cep the common stall control.
    assign cnt_en   = cep & cet;
    assign all_ones = &cnt_q;

    // Load outranks count, and a load at all-ones takes d (no wrap).
    always_ff @(posedge clk or negedge mrn) begin
        if (!mrn) begin
            cnt_q <= '0;
        end else if (!pen) begin
            cnt_q <= d;
        end else if (cnt_en) begin
            cnt_q <= cnt_q + 1'b1;   // all-ones wraps to zero naturally
        end
    end

    // Combinational so a cascade's upper stage sees the carry within the
    // same cycle; deliberately independent of cep.
    assign tc = cet & all_ones;

`ifdef COUNTER161_OE_EN
    assign q = oen ? {WIDTH{1'bz}} : cnt_q;
`else
    assign q = cnt_q;
`endif

endmodule

// File: tb/tb_binary_counter_161.sv
module tb_binary_counter_161;

    localparam int WIDTH = 4;
    localparam int MOD   = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             mrn, pen, cep, cet;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             tc;
`ifdef COUNTER161_OE_EN
    logic             oen = 1'b0;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int exp_q  = 0;   // reference count value, plain integer arithmetic

    binary_counter_161 #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .mrn (mrn),
        .pen (pen),
        .cep (cep),
        .cet (cet),
        .d   (d),
`ifdef COUNTER161_OE_EN
        .oen (oen),
`endif
        .q   (q),
        .tc  (tc)
    );

    always #5 clk = ~clk;

    // One rising edge: the reference model applies the counter rules to the
    // inputs present at the edge, then outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        if (!mrn)                 exp_q = 0;
        else if (!pen)            exp_q = int'(d);
        else if (cep && cet)      exp_q = (exp_q + 1) % MOD;
        #1;
    endtask

    function automatic logic exp_tc();
        return cet && (exp_q == MOD - 1);
    endfunction

    task automatic test_reset();
        mrn = 1'b0; pen = 1'b0; cep = 1'b1; cet = 1'b1; d = 4'hF;
        #3;
        exp_q = 0;
        n_chk++;
        if (q !== 4'h0 || tc !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_initial: q=%h tc=%b, expected q=0 tc=0", q, tc);
        end
        // Edges with a pending load must be ignored while mrn is low.
        for (int i = 0; i < 2; i++) begin
            tick();
            n_chk++;
            if (q !== 4'h0) begin
                n_fail++;
                $display("FAIL reset_hold_load: q=%h, expected 0", q);
            end
        end
        mrn = 1'b1; pen = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        n_chk++;
        if (q !== 4'd5) begin
            n_fail++;
            $display("FAIL reset_count5: q=%h, expected 5", q);
        end
        // Mid-cycle assertion must clear q before the next edge.
        #2 mrn = 1'b0;
        exp_q = 0;
        #1;
        n_chk++;
        if (q !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_async: q=%h, expected 0 before edge", q);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_chk++;
            if (q !== 4'h0) begin
                n_fail++;
                $display("FAIL reset_hold_count: q=%h, expected 0", q);
            end
        end
        mrn = 1'b1;
    endtask

    task automatic test_count();
        pen = 1'b1; cep = 1'b1; cet = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            n_chk++;
            if (q !== 4'(i) || tc !== (i == 15)) begin
                n_fail++;
                $display("FAIL count_step%0d: q=%h tc=%b, expected q=%h tc=%b",
                         i, q, tc, 4'(i), (i == 15));
            end
        end
        tick();
        n_chk++;
        if (q !== 4'h0 || tc !== 1'b0) begin
            n_fail++;
            $display("FAIL count_wrap: q=%h tc=%b, expected q=0 tc=0", q, tc);
        end
    endtask

    task automatic test_load_priority();
        pen = 1'b0; d = 4'h7; tick();
        pen = 1'b0; d = 4'hA; cep = 1'b0; cet = 1'b0; tick();
        n_chk++;
        if (q !== 4'hA) begin
            n_fail++;
            $display("FAIL load_no_en: q=%h, expected a", q);
        end
        pen = 1'b0; d = 4'h7; tick();
        pen = 1'b0; d = 4'hA; cep = 1'b1; cet = 1'b1; tick();
        n_chk++;
        if (q !== 4'hA) begin
            n_fail++;
            $display("FAIL load_over_count: q=%h, expected a", q);
        end
        // Load at all-ones must take d, not wrap.
        pen = 1'b0; d = 4'hF; tick();
        pen = 1'b0; d = 4'h4; tick();
        n_chk++;
        if (q !== 4'h4) begin
            n_fail++;
            $display("FAIL load_at_max: q=%h, expected 4", q);
        end
    endtask

    task automatic test_hold();
        pen = 1'b0; d = 4'h3; tick();
        pen = 1'b1;
        for (int k = 0; k < 2; k++) begin
            cep = (k == 1); cet = (k == 0);
            for (int i = 0; i < 2; i++) begin
                tick();
                n_chk++;
                if (q !== 4'h3) begin
                    n_fail++;
                    $display("FAIL hold_cep%0b_cet%0b: q=%h, expected 3", cep, cet, q);
                end
            end
        end
    endtask

    task automatic test_tc_gating();
        logic exp_seq [3];
        exp_seq[0] = 1'b1; exp_seq[1] = 1'b0; exp_seq[2] = 1'b1;
        pen = 1'b0; d = 4'hF; cep = 1'b0; cet = 1'b1; tick();
        pen = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cet = exp_seq[i];
            #1;
            n_chk++;
            if (tc !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL tc_follow_cet%0d: tc=%b, expected %b", i, tc, exp_seq[i]);
            end
        end
        cep = 1'b0; cet = 1'b1; #1;
        n_chk++;
        if (tc !== 1'b1 || q !== 4'hF) begin
            n_fail++;
            $display("FAIL tc_no_cep: tc=%b q=%h, expected tc=1 q=f", tc, q);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            pen = ($urandom_range(0, 7) != 0);
            cep = ($urandom_range(0, 3) != 0);
            cet = ($urandom_range(0, 3) != 0);
            d   = 4'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                @(negedge clk);
                mrn = 1'b0;
                exp_q = 0;
                #1;
                n_chk++;
                if (q !== 4'h0) begin
                    n_fail++;
                    $display("FAIL rand_async_reset%0d: q=%h, expected 0", i, q);
                end
                mrn = 1'b1;
            end
            #1;
            n_chk++;
            if (tc !== exp_tc()) begin
                n_fail++;
                $display("FAIL rand_tc_comb%0d: tc=%b, expected %b", i, tc, exp_tc());
            end
            tick();
            n_chk++;
            if (q !== 4'(exp_q) || tc !== exp_tc()) begin
                n_fail++;
                $display("FAIL rand_step%0d: q=%h tc=%b, expected q=%h tc=%b",
                         i, q, tc, 4'(exp_q), exp_tc());
            end
        end
    endtask

`ifdef COUNTER161_OE_EN
    task automatic test_oe();
        pen = 1'b0; d = 4'h6; cep = 1'b1; cet = 1'b1; tick();
        oen = 1'b1; #1;
        n_chk++;
        if (q !== 4'bzzzz) begin
            n_fail++;
            $display("FAIL oe_tristate: q=%b, expected zzzz", q);
        end
        pen = 1'b1;
        tick(); tick();
        n_chk++;
        if (q !== 4'bzzzz) begin
            n_fail++;
            $display("FAIL oe_tristate_counting: q=%b, expected zzzz", q);
        end
        oen = 1'b0; #1;
        n_chk++;
        if (q !== 4'h8) begin
            n_fail++;
            $display("FAIL oe_reenable: q=%h, expected 8", q);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_count();
        test_load_priority();
        test_hold();
        test_tc_gating();
        test_random();
`ifdef COUNTER161_OE_EN
        test_oe();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Hard bound so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded bound, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/binary_counter_161.md
Name: binary_counter_161

Overview:
- 4-bit presettable synchronous binary counter, functionally equivalent to a 74x161.
- Used as the microcode step counter in the control logic.
- Parallel-load input allows a step reset; count-enable inputs allow stalling.
- Terminal-count output allows cascading several counters into wider ones.

Parameters:
- WIDTH, 4: counter width in bits. All behaviour below generalises to WIDTH bits; the all-ones value is 2^WIDTH-1.

Ports:
- clk  input  1  counting clock; all state changes except reset occur on its rising edge
- mrn  input  1  master reset, asynchronous, active-low
- pen  input  1  parallel load enable, synchronous, active-low
- cep  input  1  count enable (parallel), active-high
- cet  input  1  count enable (trickle), active-high; also gates tc
- d    input  WIDTH  parallel load data
- q    output WIDTH  counter state
- tc   output 1  terminal count

Behaviour:
- Reset:
  - mrn=0 forces q=0 immediately, without waiting for a clock edge.
  - While mrn is low, q stays 0 and clock edges are ignored.
  - tc=0 during reset, because q is not all-ones.
- Release:
  - Deassertion of mrn takes effect with no extra delay.
  - The first rising clk edge after release is processed normally.
- Rising clk edge with mrn=1, in priority order:
  1. pen=0: q <= d. Load ignores cep and cet.
  2. pen=1, cep=1 and cet=1: q <= q+1 modulo 2^WIDTH. All-ones wraps to 0.
  3. Otherwise: q holds.
- Terminal count:
  - tc = cet AND (q == all-ones).
  - tc is purely combinational: it follows cet with no clock latency.
  - tc does not depend on cep.
- Output timing:
  - q is registered and updates one clk edge after the controlling inputs are sampled.
  - There is no combinational path from d, pen or cep to q.
- Simultaneous events:
  - mrn=0 overrides any load or count on the same edge.
  - A load on the edge where q is all-ones still loads d; there is no wrap.
- Undriven or X inputs are not treated specially.
- Power-up before the first reset is undefined.
- Cascading:
  - Connect tc of the lower stage to cet of the next stage.
  - Drive cep of every stage from a common enable.

Optional Feature:
- Macro: COUNTER161_OE_EN.
- With the macro defined:
  - An extra input oen (1 bit, active-low output enable) is added.
  - q is driven when oen=0 and is high-impedance (all Z) when oen=1.
  - The internal state and tc are unaffected by oen.
  - Counting, loading and reset continue while outputs are tri-stated.
- Without the macro:
  - There is no oen port.
  - q is always driven.

Test Plan:
- Async reset: count to 5, then pull mrn low between clock edges -> q=0 immediately, before the next edge. Edges while mrn=0 -> q stays 0.
- Count: mrn=1, pen=1, cep=cet=1, 3 edges from 0 -> q=1,2,3. Continue to 15 -> tc=1. Next edge -> q=0, tc=0.
- Load priority: q=7, pen=0, d=4'hA, cep=0, cet=0, one edge -> q=4'hA. Repeat with cep=cet=1 -> still q=4'hA.
- Hold: q=3, cep=0/cet=1 and cep=1/cet=0, 2 edges each -> q=3 throughout.
- tc gating: load 15, cet toggles 1->0->1 with no clock -> tc follows 1->0->1. With cep=0 and cet=1 -> tc=1.
- With COUNTER161_OE_EN: q=6, oen=1 -> q all Z. Count 2 edges, then oen=0 -> q=8.
